// File: rtl/mega_mux_arbiter.sv
// Purpose : 8-requester round-robin arbiter driving the select of an 8:1 32-bit mux.
// Latency : 1 cycle from req to grant; back-to-back regrant on transfer, no bubble.
// Backpres: while out_ready is low the grant is frozen and req changes are ignored.
//
// Ports   : clk, rst (sync, active-high), req[7:0], lock[7:0] (ARB_LOCK_EN only),
//           out_ready -> sel[2:0], grant[7:0] (one-hot), out_valid. All outputs registered.
// Config  : define ARB_LOCK_EN to compile in the lock port and burst-hold counter
//           (MAX_HOLD = max consecutive transfers one locked requester may win).
module mega_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef ARB_LOCK_EN
  input  logic [7:0] lock,
`endif
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       out_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;

  // First set bit of r in order p, p+1, ..., p+7 (mod 8). Rotating r right by p
  // makes the search a plain lowest-set-bit scan; the 3-bit add wraps the index back.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    dbl = {r, r} >> p;
    rot = dbl[7:0];
    off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
    return p + off;
  endfunction

  logic [2:0] idle_pick;
  logic [2:0] rot_ptr;
  logic [7:0] masked;
  logic [2:0] rot_pick;
  logic       hold_ok;

`ifdef ARB_LOCK_EN
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
`endif

  always_comb begin
    idle_pick = rr_pick(req, ptr);
    rot_ptr   = sel + 3'd1;
    // In GRANT, grant is exactly the winner's one-hot, so this drops the winner's bit.
    masked    = req & ~grant;
    rot_pick  = rr_pick(masked, rot_ptr);
`ifdef ARB_LOCK_EN
    // Locked winner keeps the bus while it still wants it and has hold budget left.
    hold_ok   = lock[sel] && req[sel] && ((int'(hold_cnt) + 1) < MAX_HOLD);
`else
    hold_ok   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      grant     <= 8'd0;
      out_valid <= 1'b0;
`ifdef ARB_LOCK_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel       <= idle_pick;
            grant     <= 8'd1 << idle_pick;
            out_valid <= 1'b1;
            state     <= GRANT;
          end else begin
            sel       <= 3'd0;
            grant     <= 8'd0;
            out_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (out_ready) begin
`ifdef ARB_LOCK_EN
            if (hold_ok) hold_cnt <= hold_cnt + HW'(1);
            else         hold_cnt <= '0;
`endif
            // A held regrant leaves sel/grant/ptr untouched.
            if (!hold_ok) begin
              ptr <= rot_ptr;
              if (|masked) begin
                sel       <= rot_pick;
                grant     <= 8'd1 << rot_pick;
                out_valid <= 1'b1;
              end else begin
                sel       <= 3'd0;
                grant     <= 8'd0;
                out_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mega_mux_arbiter.sv
// Purpose : self-checking bench for mega_mux_arbiter: directed scenarios with literal
//           expectations plus randomized traffic checked every cycle against a model.
// Latency : model tracks the DUT cycle-for-cycle; outputs sampled on the falling edge.
// Backpres: out_ready driven randomly to exercise grant hold and back-to-back transfers.
module tb_mega_mux_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
`ifdef ARB_LOCK_EN
  logic [7:0] lock;
`endif
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mega_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid)
  );

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  int m_win   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [7:0] rest;
    bit         keep;
    if (rst) begin
      m_valid = 1'b0; m_win = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_valid) begin
      if (req != 8'd0) begin
        m_win   = pick(req, m_ptr);
        m_valid = 1'b1;
      end
    end else if (out_ready) begin
      keep = 1'b0;
`ifdef ARB_LOCK_EN
      keep = lock[m_win] && req[m_win] && (m_hold + 1 < MAX_HOLD);
`endif
      if (keep) begin
        m_hold = m_hold + 1;
      end else begin
        m_hold = 0;
        m_ptr  = (m_win + 1) % 8;
        rest   = req;
        rest[m_win] = 1'b0;
        if (rest != 8'd0) m_win = pick(rest, m_ptr);
        else begin m_valid = 1'b0; m_win = 0; end
      end
    end
  end

  function automatic logic [7:0] m_grant();
    return m_valid ? (8'd1 << m_win) : 8'd0;
  endfunction

  function automatic logic [2:0] m_sel();
    return m_valid ? 3'(m_win) : 3'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One compare process: DUT against model on every falling edge once reset is done.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_grant", {24'd0, grant}, {24'd0, m_grant()});
      chk("model_sel", {29'd0, sel}, {29'd0, m_sel()});
      chk("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'd0; out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 8'd0;
`endif
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'd0; out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 8'd0;
`endif
    step();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state and quiet idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_grant", {24'd0, grant}, 32'h0);
      chk("idle_sel", {29'd0, sel}, 32'h0);
      chk("idle_valid", {31'd0, out_valid}, 32'h0);
    end

    // All requesters active, always ready: 01,02,...,80,01.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] e;
      e = 8'd1 << (i % 8);
      step();
      chk("rotate_grant", {24'd0, grant}, {24'd0, e});
      chk("rotate_sel", {29'd0, sel}, 32'(i % 8));
      chk("rotate_model", {24'd0, m_grant()}, {24'd0, e});
    end

    // Stall holds the grant; transfer moves to the other requester.
    do_reset();
    req = 8'h24; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_grant", {24'd0, grant}, 32'h04);
    end
    out_ready = 1'b1;
    chk("stall_grant4", {24'd0, grant}, 32'h04);
    step();
    chk("after_stall_grant", {24'd0, grant}, 32'h20);
    chk("after_stall_sel", {29'd0, sel}, 32'd5);

    // Pointer wrap after index 7.
    do_reset();
    req = 8'h80; out_ready = 1'b1;
    step();
    chk("wrap_first", {24'd0, grant}, 32'h80);
    req = 8'h81;
    step();
    chk("wrap_next", {24'd0, grant}, 32'h01);
    step();
    chk("wrap_back", {24'd0, grant}, 32'h80);

    // Single requester: transfer, bubble, regrant.
    do_reset();
    req = 8'h10; out_ready = 1'b1;
    step(); chk("single_g1", {24'd0, grant}, 32'h10);
    step(); chk("single_bubble", {31'd0, out_valid}, 32'h0);
    step(); chk("single_g2", {24'd0, grant}, 32'h10);

    // Reset during a stalled grant drops it and restarts the pointer at 0.
    do_reset();
    req = 8'h08; out_ready = 1'b0;
    step(); chk("rg_grant", {24'd0, grant}, 32'h08);
    rst = 1'b1; out_ready = 1'b1;
    step();
    chk("rg_valid", {31'd0, out_valid}, 32'h0);
    chk("rg_cleared", {24'd0, grant}, 32'h00);
    rst = 1'b0; req = 8'h09;
    step(); chk("rg_regrant", {24'd0, grant}, 32'h01);

`ifdef ARB_LOCK_EN
    // Locked burst: four transfers to requester 0, then requester 1.
    do_reset();
    req = 8'h03; lock = 8'h01; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("lock_hold", {24'd0, grant}, 32'h01);
    end
    step(); chk("lock_release", {24'd0, grant}, 32'h02);
`endif

    // Randomized traffic checked by the compare process.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : req;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
      lock      = 8'($urandom_range(0, 255));
`endif
      step();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mega_mux_arbiter.md
MEGA_MUX_ARBITER -- requirements
Module: mega_mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, max consecutive transfers one locked requester may win (used only with ARB_LOCK_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request from requester i for the 8:1 32-bit select mux; held high until its transfer completes.
REQ-005 lock  input  8  burst-lock from requester i; present only when ARB_LOCK_EN is defined.
REQ-006 out_ready  input  1  downstream accepts the mux output this cycle.
REQ-007 sel  output  3  mux select, binary index of current winner.
REQ-008 grant  output  8  one-hot grant, grant[sel] when valid, else all zero.
REQ-009 out_valid  output  1  mux output valid; transfer occurs when out_valid and out_ready both high.

Function
REQ-010 The block SHALL implement two states: IDLE and GRANT.
REQ-011 All outputs SHALL be registered; no combinational path from req/out_ready to outputs.
REQ-012 A round-robin pointer ptr (3 bits) SHALL hold the highest-priority index; search order ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-013 IDLE: if req != 0, the first set req bit in search order SHALL be granted on the next edge (1-cycle latency): sel=index, grant=one-hot, out_valid=1, state GRANT; if req == 0, stay IDLE, outputs zero.
REQ-014 GRANT without transfer (out_ready=0): sel, grant, out_valid SHALL hold unchanged; req changes SHALL be ignored.
REQ-015 GRANT with transfer: ptr SHALL become winner+1 modulo 8 (7 wraps to 0); re-arbitration SHALL use the updated ptr and current req with the winner's bit masked.
REQ-016 After transfer, if any masked req bit is set, the new winner SHALL be granted on the next edge with out_valid staying 1 (back-to-back, no IDLE bubble); else state IDLE, out_valid=0, grant=0, sel=0.
REQ-017 With all 8 requesters continuously active, grants SHALL rotate 0,1,...,7,0 with one transfer per cycle when out_ready=1.
REQ-018 A single requester asserting req continuously SHALL be granted every other cycle (transfer, then IDLE, then regrant) unless lock applies.
REQ-019 grant SHALL never have more than one bit set; sel SHALL equal the index of the set grant bit whenever out_valid=1.

Reset
REQ-020 On rst high at a rising edge: state IDLE, ptr=0, sel=0, grant=0, out_valid=0, hold count=0.
REQ-021 Reset asserted during GRANT SHALL drop the grant at that edge with no transfer recorded and no ptr advance beyond 0.
REQ-022 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-023 Macro ARB_LOCK_EN SHALL compile in the lock port and burst-hold logic.
REQ-024 With ARB_LOCK_EN: on transfer, if lock[winner] and req[winner] are high and hold count+1 < MAX_HOLD, the same winner SHALL be regranted back-to-back, ptr not advanced, hold count incremented.
REQ-025 With ARB_LOCK_EN: when hold count+1 reaches MAX_HOLD, or lock drops, normal REQ-015 rotation SHALL apply and hold count SHALL clear to 0.
REQ-026 Without ARB_LOCK_EN: no lock port, no hold counter; behaviour exactly REQ-010..REQ-019.

Verification
REQ-027 rst 1 cycle, req=8'h00 -> sel=0, grant=8'h00, out_valid=0 for 5 cycles.
REQ-028 req=8'hFF, out_ready=1 constant -> grant sequence 8'h01,8'h02,...,8'h80,8'h01 on consecutive cycles, sel 0..7,0.
REQ-029 req=8'h24, out_ready=0 for 3 cycles then 1 -> grant=8'h04 held 4 cycles, then grant=8'h20, sel=5 next cycle.
REQ-030 req=8'h81 after a transfer by index 7 (ptr wraps to 0) -> next grant 8'h01, then 8'h80.
REQ-031 grant=8'h08 with out_ready=0, rst pulsed -> next cycle out_valid=0, grant=8'h00, then req=8'h09 grants 8'h01 (ptr=0).
REQ-032 ARB_LOCK_EN, MAX_HOLD=4, req=8'h03, lock=8'h01, out_ready=1 -> grant 8'h01 for 4 consecutive transfers, then 8'h02.
